// File: rtl/siso_pkg.sv
// siso_pkg: default delay depth and reset value shared by the siso delay line
package siso_pkg;
  localparam int DEF_DEPTH = 4;
  localparam logic DEF_RESET_VAL = 1'b0;
endpackage

// File: rtl/siso_if.sv
// siso_if: serial stream bundle; si is driven by the producer, so by the delay line
interface siso_if;
  logic si;
  logic so;
  modport master (output si, input so);
  modport slave (input si, output so);
endinterface

// File: rtl/siso_dff.sv
// siso_dff: single D flop with sync active-high reset; ports clk, rst, d, q
module siso_dff import siso_pkg::*; #(
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= rst ? RESET_VAL : d;
endmodule

// File: rtl/siso.sv
// siso: DEPTH-cycle serial delay line; ports clk, rst, bus.si in, bus.so out (registered)
module siso import siso_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter logic RESET_VAL = DEF_RESET_VAL
) (
  input logic clk,
  input logic rst,
  siso_if.slave bus
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("siso: DEPTH must be >= 1");
  end
  logic [DEPTH:0] chain;
  assign chain[0] = bus.si;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    siso_dff #(.RESET_VAL(RESET_VAL)) u_dff (
      .clk(clk),
      .rst(rst),
      .d(chain[i]),
      .q(chain[i+1])
    );
  end
  assign bus.so = chain[DEPTH];
endmodule

// File: tb/tb_siso.sv
// tb_siso: scoreboard bench for siso at DEPTH=4, DEPTH=1 and RESET_VAL=1
module tb_siso;
  typedef struct {
    logic e4;
    logic e1;
    logic er;
    string nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  bit hist[$];
  siso_if b4();
  siso_if b1();
  siso_if br();
  siso u4 (.clk(clk), .rst(rst), .bus(b4));
  siso #(.DEPTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  siso #(.DEPTH(4), .RESET_VAL(1'b1)) ur (.clk(clk), .rst(rst), .bus(br));
  always #50 clk = ~clk;
  task automatic step(input logic r, input logic s, input logic e4, input logic e1, input logic er, input string nm);
    exp_t e;
    @(negedge clk);
    #25;
    rst = r;
    b4.si = s;
    b1.si = s;
    br.si = s;
    e.e4 = e4;
    e.e1 = e1;
    e.er = er;
    e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic chk(input string nm, input string dut, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: so=%b expected %b at %0t", nm, dut, act, exp, $time);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "depth4", b4.so, e.e4);
        chk(e.nm, "depth1", b1.so, e.e1);
        chk(e.nm, "rv1", br.so, e.er);
      end
    end
  end
  initial begin : driver
    logic [28:0] v_rst, v_si, v_e4, v_e1, v_er;
    string nm;
    int j;
    bit s;
    v_rst = 29'b11_00000000_0000000000_0001_00000;
    v_si  = 29'b11_10011111_0000100000_1110_00000;
    v_e4  = 29'b00_00010011_1110000100_0000_00000;
    v_e1  = 29'b00_10011111_0000100000_1110_00000;
    v_er  = 29'b11_11110011_1110000100_0001_11100;
    b4.si = 1'b0;
    b1.si = 1'b0;
    br.si = 1'b0;
    for (int k = 0; k < 29; k++) begin
      nm = k < 2 ? "reset" : k < 10 ? "pattern" : k < 20 ? "latency" : "mid_reset";
      step(v_rst[28-k], v_si[28-k], v_e4[28-k], v_e1[28-k], v_er[28-k], nm);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "reset2");
    for (int k = 0; k < 200; k++) begin
      s = 1'($urandom_range(0, 1));
      hist.push_back(s);
      j = hist.size() - 1;
      step(1'b0, s, j >= 3 ? hist[j-3] : 1'b0, hist[j], j >= 3 ? hist[j-3] : 1'b1, "random");
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
